mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface. Sits in the MEM stage between the pipeline and the word-addressed data memory.
- Accepts byte-addressed load/store requests of size byte, half or word, with signed or unsigned loads.
- Sequences them into the memory's read/write/adr/data strobes; sub-word stores use read-modify-write.
- Returns extracted load data and holds the pipeline with a stall until each access completes.

Parameters:
- LEN_DATA, 32: data and byte-address width; default taken from `LEN_DATA in defs.v.
- SIZE_MEM, 1024: depth of the memory in words; default taken from `SIZE_MEM in defs.v.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  access requested this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as word.
- req_signed  in  1  sign-extend sub-word loads.
- req_adr  in  LEN_DATA  byte address.
- req_wdata  in  LEN_DATA  store data, right-aligned.
- stall  out  1  pipeline hold.
- ack  out  1  one-cycle completion pulse.
- err  out  1  valid with ack: misaligned or out-of-range access.
- rdata  out  LEN_DATA  load result, valid with ack.
- mem_read  out  1  to memory read.
- mem_write  out  1  to memory write.
- mem_adr  out  LEN_DATA  word index = byte address >> 2.
- mem_data  out  LEN_DATA  full word to write.
- mem_out  in  LEN_DATA  memory read data, combinational from mem_adr.

Behaviour:
- Reset values (on a rst edge): state = IDLE; ack, err, rdata, mem_read, mem_write, mem_adr, mem_data all 0.
- FSM states: IDLE, RD, WR, DONE.
- IDLE, req_valid = 1: latch size, signed, offset = adr[1:0], word index, and wdata.
  - Misaligned (half with adr[0] = 1, or word with adr[1:0] != 0) or word index >= SIZE_MEM: go to DONE with err = 1 and no memory strobe.
  - Load or sub-word store: go to RD.
  - Word store: go to WR.
- RD: mem_read = 1 and mem_adr = index. At the edge, capture mem_out into a buffer.
  - Load: go to DONE.
  - Sub-word store: go to WR.
- WR: mem_write = 1, mem_adr = index.
  - mem_data = wdata for a word store.
  - Otherwise mem_data = buffer with only the target lane replaced. Little-endian lanes: offset 0 = bits[7:0]; a half at offset 2 = bits[31:16].
  - Then go to DONE.
- DONE: ack = 1; rdata = extracted lane (zero- or sign-extended), 0 for stores and errors. Next state is IDLE.
- Strobe timing: mem_read and mem_write are registered and never high together. Both are 0 outside RD and WR. mem_adr and mem_data are held stable for the whole strobe cycle and are 0 when idle.
- stall = req_valid & ~ack. The pipeline advances in the DONE cycle.
- Latency from the first req_valid cycle (cycle 0):
  - Load: ack in cycle 2.
  - Word store: ack in cycle 2.
  - Sub-word store: ack in cycle 3.
  - Error: ack in cycle 1.
- The request is latched in IDLE. Input changes while busy are ignored.
- In DONE, a pending req_valid is not sampled; it is accepted in the following IDLE cycle, so back-to-back requests incur one IDLE cycle.
- Reset mid-operation: return to IDLE at that edge; the strobe drops. An RMW reset in RD performs no write.
- rdata and err are meaningful only while ack = 1; they are cleared to 0 on the cycle after ack.

Decomposition:
- defs.v gains size codes (`SZ_BYTE, `SZ_HALF, `SZ_WORD) and FSM state encodings (2 bits).
- One sub-module, lane_align: a combinational block that does both extract (word, offset, size, signed → rdata) and merge (word, wdata, offset, size → new word).
- The FSM and registers stay in mem_access_unit.

Test Plan:
- Memory preloaded word[4] = 32'h8899AABB; lw adr = 16 -> mem_read for 1 cycle with mem_adr = 4; ack in cycle 2; rdata = 32'h8899AABB; stall high in cycles 0–1.
- lb signed at adr = 16, then lbu at adr = 19 -> rdata = 32'hFFFFFFBB, then 32'h00000088.
- sb wdata = 32'h12 at adr = 17 over word 32'h8899AABB -> RD then WR; mem_data = 32'h889912BB; ack in cycle 3; a subsequent lw returns the same value.
- sh wdata = 32'h5566 at adr = 18 -> stored word = 32'h5566AABB. Then lh signed at adr = 18 -> rdata = 32'h00005566.
- lw adr = 18 (misaligned) and sw adr = 4*SIZE_MEM -> ack in cycle 1 with err = 1; mem_read and mem_write are never asserted.
- rst asserted during the RD cycle of an sb -> next cycle state = IDLE with all outputs 0; no mem_write pulse; memory word unchanged.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared constants, size codes and FSM state type for the data-memory access unit.
package mem_access_unit_pkg;

  localparam int DEF_LEN_DATA = 32;
  localparam int DEF_SIZE_MEM = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    DONE = 2'b11
  } state_e;

  // The reserved size code 2'b11 behaves exactly like a word access.
  function automatic logic is_word(input logic [1:0] size);
    return (size == SZ_WORD) || (size == 2'b11);
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    return ((size == SZ_HALF) && offset[0]) || (is_word(size) && (offset != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and data-memory strobe bundle; master is the access unit.
interface mem_access_unit_if
  import mem_access_unit_pkg::*;
#(
  parameter int LEN_DATA = DEF_LEN_DATA
);

  logic                req_valid;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [LEN_DATA-1:0] req_adr;
  logic [LEN_DATA-1:0] req_wdata;
  logic                stall;
  logic                ack;
  logic                err;
  logic [LEN_DATA-1:0] rdata;
  logic                mem_read;
  logic                mem_write;
  logic [LEN_DATA-1:0] mem_adr;
  logic [LEN_DATA-1:0] mem_data;
  logic [LEN_DATA-1:0] mem_out;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_adr, req_wdata, mem_out,
    output stall, ack, err, rdata, mem_read, mem_write, mem_adr, mem_data
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_adr, req_wdata, mem_out,
    input  stall, ack, err, rdata, mem_read, mem_write, mem_adr, mem_data
  );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extracts a load lane from a word and merges a store lane into one.
module lane_align
  import mem_access_unit_pkg::*;
#(
  parameter int LEN_DATA = DEF_LEN_DATA
) (
  input  logic [LEN_DATA-1:0] word_i,
  input  logic [LEN_DATA-1:0] wdata_i,
  input  logic [1:0]          offset_i,
  input  logic [1:0]          size_i,
  input  logic                signed_i,
  output logic [LEN_DATA-1:0] rdata_o,
  output logic [LEN_DATA-1:0] merged_o
);

  logic [4:0]          shamt;
  logic [LEN_DATA-1:0] shifted;
  logic [LEN_DATA-1:0] laneMask;

  assign shamt   = {offset_i, 3'b000};
  assign shifted = word_i >> shamt;

  always_comb begin
    rdata_o  = word_i;
    laneMask = '1;
    case (size_i)
      SZ_BYTE: begin
        rdata_o  = {{(LEN_DATA-8){signed_i & shifted[7]}}, shifted[7:0]};
        laneMask = LEN_DATA'(8'hFF);
      end
      SZ_HALF: begin
        rdata_o  = {{(LEN_DATA-16){signed_i & shifted[15]}}, shifted[15:0]};
        laneMask = LEN_DATA'(16'hFFFF);
      end
      default: ;
    endcase
  end

  // Keep every byte of the old word except the target lane, which takes the store data.
  assign merged_o = (word_i & ~(laneMask << shamt)) | ((wdata_i & laneMask) << shamt);

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: turns byte-addressed loads/stores into word-memory strobes,
// using read-modify-write for sub-word stores and stalling the pipeline until done.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int LEN_DATA = DEF_LEN_DATA,
  parameter int SIZE_MEM = DEF_SIZE_MEM
) (
  input logic clk,
  input logic rst,
  mem_access_unit_if.master bus
);

  state_e              state_q, state_d;
  logic                write_q, write_d;
  logic                signed_q, signed_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          offset_q, offset_d;
  logic [LEN_DATA-1:0] index_q, index_d;
  logic [LEN_DATA-1:0] wdata_q, wdata_d;

  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [LEN_DATA-1:0] rdata_q, rdata_d;
  logic                memRead_q, memRead_d;
  logic                memWrite_q, memWrite_d;
  logic [LEN_DATA-1:0] memAdr_q, memAdr_d;
  logic [LEN_DATA-1:0] memData_q, memData_d;

  logic [LEN_DATA-1:0] reqIndex;
  logic                reqBad;
  logic [LEN_DATA-1:0] extracted;
  logic [LEN_DATA-1:0] merged;

  assign reqIndex = {2'b00, bus.req_adr[LEN_DATA-1:2]};
  assign reqBad   = is_misaligned(bus.req_size, bus.req_adr[1:0]) ||
                    (reqIndex >= LEN_DATA'(SIZE_MEM));

  // Lane logic works straight off mem_out during RD; its results are registered as the read buffer.
  lane_align #(.LEN_DATA(LEN_DATA)) u_lane_align (
    .word_i   (bus.mem_out),
    .wdata_i  (wdata_q),
    .offset_i (offset_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .rdata_o  (extracted),
    .merged_o (merged)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    signed_d   = signed_q;
    size_d     = size_q;
    offset_d   = offset_q;
    index_d    = index_q;
    wdata_d    = wdata_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdata_d    = '0;
    memRead_d  = 1'b0;
    memWrite_d = 1'b0;
    memAdr_d   = '0;
    memData_d  = '0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d  = bus.req_write;
          signed_d = bus.req_signed;
          size_d   = bus.req_size;
          offset_d = bus.req_adr[1:0];
          index_d  = reqIndex;
          wdata_d  = bus.req_wdata;
          if (reqBad) begin
            state_d = DONE;
            ack_d   = 1'b1;
            err_d   = 1'b1;
          end else if (!bus.req_write || !is_word(bus.req_size)) begin
            state_d   = RD;
            memRead_d = 1'b1;
            memAdr_d  = reqIndex;
          end else begin
            state_d    = WR;
            memWrite_d = 1'b1;
            memAdr_d   = reqIndex;
            memData_d  = bus.req_wdata;
          end
        end
      end
      RD: begin
        if (write_q) begin
          state_d    = WR;
          memWrite_d = 1'b1;
          memAdr_d   = index_q;
          memData_d  = merged;
        end else begin
          state_d = DONE;
          ack_d   = 1'b1;
          rdata_d = extracted;
        end
      end
      WR: begin
        state_d = DONE;
        ack_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      signed_q   <= 1'b0;
      size_q     <= SZ_BYTE;
      offset_q   <= 2'b00;
      index_q    <= '0;
      wdata_q    <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memAdr_q   <= '0;
      memData_q  <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      signed_q   <= signed_d;
      size_q     <= size_d;
      offset_q   <= offset_d;
      index_q    <= index_d;
      wdata_q    <= wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      memAdr_q   <= memAdr_d;
      memData_q  <= memData_d;
    end
  end

  assign bus.stall     = bus.req_valid & ~ack_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_read  = memRead_q;
  assign bus.mem_write = memWrite_q;
  assign bus.mem_adr   = memAdr_q;
  assign bus.mem_data  = memData_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a word-array memory, a shadow-memory reference model
// and a per-cycle compare process, plus literal expectations for the key transactions.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int LD = DEF_LEN_DATA;
  localparam int SM = DEF_SIZE_MEM;
  localparam int AW = $clog2(SM);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_access_unit_if #(.LEN_DATA(LD)) bus ();

  mem_access_unit #(.LEN_DATA(LD), .SIZE_MEM(SM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem    [SM];
  logic [31:0] refMem [SM];
  logic          pokeEn;
  logic [AW-1:0] pokeIdx;
  logic [31:0]   pokeData;

  assign bus.mem_out = (bus.mem_adr < SM) ? mem[bus.mem_adr[AW-1:0]] : '0;

  // Data memory: writes land at the clock edge that ends the write-strobe cycle.
  always @(posedge clk) begin
    if (pokeEn) mem[pokeIdx] <= pokeData;
    else if (bus.mem_write && (bus.mem_adr < SM)) mem[bus.mem_adr[AW-1:0]] <= bus.mem_data;
  end

  int errors = 0;
  int checks = 0;

  logic        checkEn = 1'b0;
  logic        expStall, expAck, expErr, expRead, expWrite;
  logic [31:0] expRdata, expAdr, expData;
  logic [31:0] lastRdata;
  logic        lastErr;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("stall", 32'(bus.stall), 32'(expStall));
      checkOutput("ack", 32'(bus.ack), 32'(expAck));
      checkOutput("err", 32'(bus.err), 32'(expErr));
      checkOutput("rdata", bus.rdata, expRdata);
      checkOutput("mem_read", 32'(bus.mem_read), 32'(expRead));
      checkOutput("mem_write", 32'(bus.mem_write), 32'(expWrite));
      checkOutput("strobe_excl", 32'(bus.mem_read & bus.mem_write), 32'd0);
      if (expRead || expWrite) checkOutput("mem_adr", bus.mem_adr, expAdr);
      if (expWrite) checkOutput("mem_data", bus.mem_data, expData);
      if (!expRead && !expWrite && !expAck) begin
        checkOutput("idle_adr", bus.mem_adr, 32'd0);
        checkOutput("idle_data", bus.mem_data, 32'd0);
      end
      if (bus.ack) begin
        lastRdata = bus.rdata;
        lastErr   = bus.err;
      end
    end
  end

  task automatic setIdleExp();
    expStall = 1'b0; expAck = 1'b0; expErr = 1'b0; expRead = 1'b0; expWrite = 1'b0;
    expRdata = '0; expAdr = '0; expData = '0;
  endtask

  task automatic applyIdle(input int n);
    bus.req_valid = 1'b0;
    setIdleExp();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pokeWord(input int idx, input logic [31:0] data);
    bus.req_valid = 1'b0;
    setIdleExp();
    pokeEn = 1'b1; pokeIdx = AW'(idx); pokeData = data;
    refMem[idx] = data;
    @(posedge clk); #1;
    pokeEn = 1'b0;
  endtask

  // Issues one request starting now (cycle 0) and walks it to its ack cycle, leaving
  // the bench at the start of the following cycle; the model decides every cycle's outputs.
  task automatic applyStimulus(input logic w, input logic [1:0] size, input logic sgn,
                               input logic [31:0] adr, input logic [31:0] wdata);
    int unsigned idx;
    int          nBytes, lat, readAt, writeAt;
    logic        bad;
    logic [31:0] rd, wrData, word, lane;
    idx     = adr / 4;
    nBytes  = (size >= 2'd2) ? 4 : ((size == 2'd1) ? 2 : 1);
    bad     = ((adr % nBytes) != 0) || (idx >= SM);
    rd      = '0;
    wrData  = '0;
    readAt  = -1;
    writeAt = -1;
    if (bad) begin
      lat = 1;
    end else begin
      word = refMem[idx];
      if (!w) begin
        lat    = 2;
        readAt = 1;
        lane   = word >> (8 * (adr % 4));
        if (nBytes < 4) begin
          lane = lane & ((32'd1 << (8 * nBytes)) - 32'd1);
          if (sgn && (lane >= (32'd1 << (8 * nBytes - 1)))) lane = lane - (32'd1 << (8 * nBytes));
        end
        rd = lane;
      end else begin
        wrData = word;
        for (int b = 0; b < nBytes; b++) wrData[8 * (int'(adr % 4) + b) +: 8] = wdata[8 * b +: 8];
        refMem[idx] = wrData;
        if (nBytes == 4) begin
          lat = 2; writeAt = 1;
        end else begin
          lat = 3; readAt = 1; writeAt = 2;
        end
      end
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_size   = size;
    bus.req_signed = sgn;
    bus.req_adr    = adr;
    bus.req_wdata  = wdata;
    for (int c = 0; c <= lat; c++) begin
      expStall = (c < lat);
      expAck   = (c == lat);
      expErr   = (c == lat) && bad;
      expRdata = ((c == lat) && !bad && !w) ? rd : 32'd0;
      expRead  = (c == readAt);
      expWrite = (c == writeAt);
      expAdr   = idx;
      expData  = wrData;
      if (c > 0) begin
        bus.req_write  = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_adr    = $urandom;
        bus.req_wdata  = $urandom;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    pokeEn = 1'b0; pokeIdx = '0; pokeData = '0;
    lastRdata = '0; lastErr = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_adr = '0; bus.req_wdata = '0;
    setIdleExp();
    @(posedge clk); #1;
    checkEn = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pokeWord(4, 32'h8899AABB);
    pokeWord(5, 32'h01234567);
    applyIdle(1);

    $display("[TB] loads");
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd16, 32'd0);
    checkOutput("lw16_pin", lastRdata, 32'h8899AABB);
    applyStimulus(1'b0, SZ_BYTE, 1'b1, 32'd16, 32'd0);
    checkOutput("lb16_pin", lastRdata, 32'hFFFFFFBB);
    applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'd19, 32'd0);
    checkOutput("lbu19_pin", lastRdata, 32'h00000088);
    applyStimulus(1'b0, SZ_HALF, 1'b0, 32'd16, 32'd0);
    checkOutput("lhu16_pin", lastRdata, 32'h0000AABB);
    applyStimulus(1'b0, SZ_HALF, 1'b1, 32'd18, 32'd0);
    checkOutput("lh18_pin", lastRdata, 32'hFFFF8899);
    applyStimulus(1'b0, 2'b11, 1'b1, 32'd20, 32'd0);
    checkOutput("lsz3_pin", lastRdata, 32'h01234567);
    applyIdle(2);

    $display("[TB] sub-word stores");
    applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'd17, 32'h00000012);
    applyIdle(1);
    checkOutput("sb17_mem_pin", mem[4], 32'h889912BB);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd16, 32'd0);
    checkOutput("sb17_lw_pin", lastRdata, 32'h889912BB);
    pokeWord(4, 32'h8899AABB);
    applyStimulus(1'b1, SZ_HALF, 1'b0, 32'd18, 32'h00005566);
    applyStimulus(1'b0, SZ_HALF, 1'b1, 32'd18, 32'd0);
    checkOutput("sh18_lh_pin", lastRdata, 32'h00005566);
    checkOutput("sh18_mem_pin", mem[4], 32'h5566AABB);

    $display("[TB] word stores and boundaries");
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'(4 * (SM - 1)), 32'hDEADBEEF);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'(4 * (SM - 1)), 32'd0);
    checkOutput("lastword_pin", lastRdata, 32'hDEADBEEF);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd18, 32'd0);
    checkOutput("lw18_err_pin", 32'(lastErr), 32'd1);
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'(4 * SM), 32'h11111111);
    checkOutput("sw_oor_err_pin", 32'(lastErr), 32'd1);
    applyStimulus(1'b1, SZ_HALF, 1'b0, 32'd17, 32'h2222);
    applyStimulus(1'b0, SZ_BYTE, 1'b0, 32'(4 * SM + 1), 32'd0);
    applyStimulus(1'b1, SZ_BYTE, 1'b0, 32'd20, 32'h000000A5);
    applyIdle(2);
    checkOutput("sb20_mem_pin", mem[5], 32'h012345A5);

    $display("[TB] reset during read-modify-write");
    pokeWord(4, 32'h8899AABB);
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = SZ_BYTE;
    bus.req_signed = 1'b0; bus.req_adr = 32'd17; bus.req_wdata = 32'h34;
    setIdleExp();
    expStall = 1'b1;
    @(posedge clk); #1;
    expRead = 1'b1; expAdr = 32'd4;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyIdle(3);
    checkOutput("rst_rmw_mem_pin", mem[4], 32'h8899AABB);
    applyStimulus(1'b0, SZ_WORD, 1'b0, 32'd16, 32'd0);
    checkOutput("rst_rmw_lw_pin", lastRdata, 32'h8899AABB);
    applyIdle(2);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
